reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised bank of DEPTH signed WIDTH-bit registers with one write port, two registered read ports and an in-place subtract mode. It is the multi-entry successor to the single `register` cell. It is the storage and reduce unit for the RSSB datapath: the core reads operands from it, then writes the subtract result back in one cycle. The core takes its skip decision from the sign flag.

## Interface
Parameters:
- WIDTH, 8, data width in bits; signed two's complement.
- DEPTH, 8, number of registers; any value ≥ 2, not necessarily a power of two.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and writes to it are ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for this cycle.
- wmode  input  2  write operation: LOAD=0, SUB=1, CLR=2, HOLD=3.
- waddr  input  $clog2(DEPTH)  target register.
- wdata  input  WIDTH signed  operand for LOAD/SUB.
- raddr_a  input  $clog2(DEPTH)  read port A address.
- raddr_b  input  $clog2(DEPTH)  read port B address.
- rdata_a  output  WIDTH signed  registered read data, port A.
- rdata_b  output  WIDTH signed  registered read data, port B.
- neg  output  1  sign of the most recent SUB result (1 = result < 0).
- zero  output  1  most recent SUB result == 0.

## Operation
- Reset: all entries, rdata_a, rdata_b, neg and zero are cleared to 0 immediately on rst assertion. They stay 0 while rst is high.
- Write. When we=1 and waddr < DEPTH, the next value nv of mem[waddr] is:
  - LOAD: nv = wdata.
  - SUB: nv = mem[waddr] − wdata, truncated to WIDTH bits (wrap-around, no saturation).
  - CLR: nv = 0.
  - HOLD: nv = mem[waddr] (no change).
- When we=0 or waddr ≥ DEPTH, no entry changes.
- With ZERO_REG=1 and waddr=0, the entry does not change, but neg/zero still update on SUB.
- Flags update only when we=1 and wmode=SUB, including the ignored-address case.
  - neg = nv[WIDTH−1]; zero = (nv == 0).
  - Otherwise the flags hold their value.
  - For an out-of-range SUB, nv is computed with an old value of 0.
- Read. Each port registers on every edge:
  - If raddr < DEPTH, the port returns the entry's value after this edge's write (write-first forwarding when waddr == raddr and the write is effective).
  - If raddr ≥ DEPTH, the port returns 0.
  - With ZERO_REG=1, entry 0 returns 0.
- Ports A and B are independent. Both may address the same entry, and both receive the same forwarded value.

## Timing
- Write latency is 1 cycle: the entry holds nv after the edge that samples we.
- Read latency is 1 cycle: rdata reflects raddr sampled at the previous edge, including a same-edge write.
- Flag latency is 1 cycle and is aligned with the SUB writeback.
- Back-to-back SUBs to the same entry on consecutive cycles chain correctly; the second SUB uses the first result.
- Asynchronous reset takes priority over any write in flight. The first write after deassertion is taken at the first rising edge with rst low.

## Structure
- `reg_bank_pkg` contains:
  - the `wmode_e` enum (LOAD, SUB, CLR, HOLD);
  - a `next_value` function (old, wdata, mode) → WIDTH-bit result.
- The package is shared with the core's control decoder.
- The storage array and the flag registers live in reg_bank.
- One sub-module is natural: `reg_bank_rdport`. It is instantiated twice, once per read port, and holds the address range check, ZERO_REG masking, write-first forwarding and the output register.

## Test plan
- Reset mid-operation:
  - Stimulus: LOAD 0x55 into entry 3, then assert rst asynchronously between edges.
  - Required: rdata_a, rdata_b, neg and zero go to 0 at once, and a read of entry 3 after reset returns 0.
- LOAD/read with forwarding:
  - Stimulus: LOAD wdata=42 to entry 2 with raddr_a=2 in the same cycle.
  - Required: rdata_a=42 one cycle later; rdata_b on entry 5 stays 0.
- SUB and flags (WIDTH=8):
  - Stimulus: entry 1 holds 5; SUB 7, then SUB −2.
  - Required: the first SUB gives entry 1 = −2 with neg=1, zero=0; the second gives 0 with neg=0, zero=1.
- Wrap-around (WIDTH=8):
  - Stimulus: entry 4 holds −128; SUB 1.
  - Required: entry 4 = 127, neg=0. CLR and LOAD leave neg/zero unchanged.
- DEPTH=6:
  - Stimulus: write to waddr=7.
  - Required: no entry changes; reading address 7 returns 0.
- ZERO_REG=1:
  - Stimulus: LOAD 9 to entry 0.
  - Required: entry 0 still reads 0; SUB 3 to entry 0 sets neg=1 with the entry unchanged.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared write-operation encoding and next-value arithmetic for the register bank and the core's control decoder.
// Purely combinational helpers; no latency and no flow control.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SUB  = 2'd1,
        CLR  = 2'd2,
        HOLD = 2'd3
    } wmode_e;

    // Widest supported data word; callers truncate the result to their own WIDTH.
    localparam int NV_MAX_W = 64;

    function automatic logic [NV_MAX_W-1:0] next_value(
        input logic [NV_MAX_W-1:0] old_v,
        input logic [NV_MAX_W-1:0] wdata,
        input wmode_e              mode
    );
        logic [NV_MAX_W-1:0] res;
        case (mode)
            LOAD:    res = wdata;
            SUB:     res = old_v - wdata;
            CLR:     res = '0;
            default: res = old_v;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port: range check, entry-0 masking, write-first forwarding.
// Latency 1 cycle; no backpressure, a new address is accepted every cycle.
module reg_bank_rdport #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH*WIDTH-1:0]   mem_flat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     wr_eff,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         nv,
    output logic signed [WIDTH-1:0]  rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;
    logic             in_range;
    logic             masked;

    always_comb begin
        rdata_d  = '0;
        in_range = ({1'b0, raddr} < DEPTH_C);
        masked   = (ZERO_REG != 0) && (raddr == '0);
        if (in_range && !masked) begin
            // A write landing on this entry at the same edge wins over the stored value.
            if (wr_eff && (waddr == raddr)) begin
                rdata_d = nv;
            end else begin
                rdata_d = mem_flat[int'(raddr)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/reg_bank.sv
// Bank of signed registers with one LOAD/SUB/CLR/HOLD write port, two read ports and SUB result flags.
// Latency 1 cycle for writes, reads and flags; no backpressure, one operation per cycle.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [1:0]               wmode,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic signed [WIDTH-1:0]  wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic signed [WIDTH-1:0]  rdata_a,
    output logic signed [WIDTH-1:0]  rdata_b,
    output logic                     neg,
    output logic                     zero
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic                   neg_d, neg_q;
    logic                   zero_d, zero_q;
    logic                   addr_ok;
    logic                   wr_eff;
    logic [WIDTH-1:0]       old_v;
    logic [WIDTH-1:0]       nv;

    always_comb begin
        addr_ok = ({1'b0, waddr} < DEPTH_C);
        // Out-of-range targets behave as an entry holding 0 so SUB still produces flags.
        old_v   = '0;
        if (addr_ok) begin
            old_v = mem_q[waddr];
        end
        nv      = WIDTH'(next_value(NV_MAX_W'(old_v), NV_MAX_W'(wdata), wmode_e'(wmode)));
        wr_eff  = we && addr_ok && !((ZERO_REG != 0) && (waddr == '0));

        mem_d = mem_q;
        if (wr_eff) begin
            mem_d[waddr] = nv;
        end

        neg_d  = neg_q;
        zero_d = zero_q;
        if (we && (wmode == SUB)) begin
            neg_d  = nv[WIDTH-1];
            zero_d = (nv == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*WIDTH +: WIDTH] = mem_q[g];
    end

    reg_bank_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rdport_a (
        .clk      (clk),
        .rst      (rst),
        .mem_flat (mem_flat),
        .raddr    (raddr_a),
        .wr_eff   (wr_eff),
        .waddr    (waddr),
        .nv       (nv),
        .rdata    (rdata_a)
    );

    reg_bank_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rdport_b (
        .clk      (clk),
        .rst      (rst),
        .mem_flat (mem_flat),
        .raddr    (raddr_b),
        .wr_eff   (wr_eff),
        .waddr    (waddr),
        .nv       (nv),
        .rdata    (rdata_b)
    );

    assign neg  = neg_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench: a default bank (d0) and a DEPTH=6, ZERO_REG=1 bank (d1) share one stimulus stream.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [1:0] wmode = 2'd0;
    logic [2:0] waddr = 3'd0;
    logic [7:0] wdata = 8'd0;
    logic [2:0] raddr_a = 3'd0;
    logic [2:0] raddr_b = 3'd0;

    logic [7:0] d0_a, d0_b, d1_a, d1_b;
    logic       d0_neg, d0_zero, d1_neg, d1_zero;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] M_LOAD = 2'd0, M_SUB = 2'd1, M_CLR = 2'd2, M_HOLD = 2'd3;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) d0 (
        .clk(clk), .rst(rst), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d0_a), .rdata_b(d0_b),
        .neg(d0_neg), .zero(d0_zero)
    );

    reg_bank #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) d1 (
        .clk(clk), .rst(rst), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d1_a), .rdata_b(d1_b),
        .neg(d1_neg), .zero(d1_zero)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] m, input logic [2:0] a, input logic [7:0] d);
        we    = w;
        wmode = m;
        waddr = a;
        wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst_a", d0_a, 8'h00);
        chk("rst_b", d0_b, 8'h00);
        chk("rst_neg", {7'd0, d0_neg}, 8'h00);
        chk("rst_zero", {7'd0, d0_zero}, 8'h00);
        rst = 1'b0;

        raddr_a = 3'd3; raddr_b = 3'd5;
        drive(1'b1, M_LOAD, 3'd3, 8'h55); step();
        chk("load3_fwd", d0_a, 8'h55);
        drive(1'b1, M_SUB, 3'd3, 8'h60); step();
        chk("sub3_val", d0_a, 8'hF5);
        chk("sub3_neg", {7'd0, d0_neg}, 8'h01);
        chk("sub3_zero", {7'd0, d0_zero}, 8'h00);
        chk("d1_sub3_val", d1_a, 8'hF5);

        // Reset asserted between edges must clear outputs without waiting for a clock.
        drive(1'b0, M_LOAD, 3'd0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", d0_a, 8'h00);
        chk("arst_neg", {7'd0, d0_neg}, 8'h00);
        chk("d1_arst_a", d1_a, 8'h00);
        #1 rst = 1'b0;
        step();
        chk("post_rst_e3", d0_a, 8'h00);

        raddr_a = 3'd2; raddr_b = 3'd5;
        drive(1'b1, M_LOAD, 3'd2, 8'd42); step();
        chk("load2_fwd", d0_a, 8'd42);
        chk("rd5_idle", d0_b, 8'h00);

        raddr_a = 3'd1;
        drive(1'b1, M_LOAD, 3'd1, 8'd5); step();
        drive(1'b1, M_SUB, 3'd1, 8'd7); step();
        chk("sub7_val", d0_a, 8'hFE);
        chk("sub7_neg", {7'd0, d0_neg}, 8'h01);
        chk("sub7_zero", {7'd0, d0_zero}, 8'h00);
        drive(1'b1, M_SUB, 3'd1, 8'hFE); step();
        chk("subm2_val", d0_a, 8'h00);
        chk("subm2_neg", {7'd0, d0_neg}, 8'h00);
        chk("subm2_zero", {7'd0, d0_zero}, 8'h01);

        raddr_a = 3'd4;
        drive(1'b1, M_LOAD, 3'd4, 8'h80); step();
        chk("load_m128", d0_a, 8'h80);
        chk("load_keeps_zero", {7'd0, d0_zero}, 8'h01);
        drive(1'b1, M_SUB, 3'd4, 8'd1); step();
        chk("wrap_val", d0_a, 8'h7F);
        chk("wrap_neg", {7'd0, d0_neg}, 8'h00);
        chk("wrap_zero", {7'd0, d0_zero}, 8'h00);
        drive(1'b1, M_CLR, 3'd4, 8'd77); step();
        chk("clr_val", d0_a, 8'h00);
        chk("clr_keeps_zero", {7'd0, d0_zero}, 8'h00);
        drive(1'b1, M_SUB, 3'd4, 8'd1); step();
        chk("sub_to_m1", d0_a, 8'hFF);
        drive(1'b1, M_LOAD, 3'd4, 8'd0); step();
        chk("load0_val", d0_a, 8'h00);
        chk("load_keeps_neg", {7'd0, d0_neg}, 8'h01);

        raddr_a = 3'd2;
        drive(1'b1, M_HOLD, 3'd2, 8'd99); step();
        chk("hold_val", d0_a, 8'd42);
        chk("hold_keeps_neg", {7'd0, d0_neg}, 8'h01);

        raddr_a = 3'd1;
        drive(1'b1, M_SUB, 3'd1, 8'd0); step();
        chk("sub0_zero", {7'd0, d0_zero}, 8'h01);

        // Address 7 exists in d0 but lies beyond d1's six entries.
        raddr_a = 3'd7; raddr_b = 3'd2;
        drive(1'b1, M_LOAD, 3'd7, 8'h33); step();
        chk("d0_load7", d0_a, 8'h33);
        chk("d1_rd7", d1_a, 8'h00);
        chk("d1_e2_intact", d1_b, 8'd42);
        drive(1'b1, M_SUB, 3'd7, 8'd5); step();
        chk("d0_sub7_val", d0_a, 8'h2E);
        chk("d0_sub7_neg", {7'd0, d0_neg}, 8'h00);
        chk("d1_oor_val", d1_a, 8'h00);
        chk("d1_oor_neg", {7'd0, d1_neg}, 8'h01);
        chk("d1_oor_zero", {7'd0, d1_zero}, 8'h00);

        raddr_a = 3'd1;
        drive(1'b1, M_SUB, 3'd1, 8'd0); step();
        chk("d1_flag_clear", {7'd0, d1_neg}, 8'h00);

        raddr_a = 3'd0;
        drive(1'b1, M_LOAD, 3'd0, 8'd9); step();
        chk("d0_load0", d0_a, 8'd9);
        chk("d1_zreg_load", d1_a, 8'h00);
        drive(1'b1, M_SUB, 3'd0, 8'd3); step();
        chk("d0_sub_e0", d0_a, 8'd6);
        chk("d0_sub_e0_neg", {7'd0, d0_neg}, 8'h00);
        chk("d1_zreg_sub", d1_a, 8'h00);
        chk("d1_zreg_neg", {7'd0, d1_neg}, 8'h01);
        drive(1'b0, M_LOAD, 3'd0, 8'd0); step();
        chk("d0_e0_stored", d0_a, 8'd6);
        chk("d1_e0_stored", d1_a, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
